// File: rtl/token_branch_scheduler.sv
// Two-way token switch controller: synchronises 4-phase send/ack channels and steers each
// token to branch A or B by weighted round-robin, with a per-token force override.
module token_branch_scheduler #(
   parameter int WEIGHT_W    = 4,
   parameter int CNT_W       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                EN,
   input  logic [WEIGHT_W-1:0] WEIGHT_A,
   input  logic [WEIGHT_W-1:0] WEIGHT_B,
   input  logic                FORCE_VALID,
   input  logic                FORCE_BR,
   input  logic                SENDIN,
   input  logic                ACKINA,
   input  logic                ACKINB,
   output logic                SENDOUTA,
   output logic                SENDOUTB,
   output logic                ACKOUT,
   output logic                BR,
   output logic                BUSY,
   output logic                ERR,
   output logic [CNT_W-1:0]    CNT_A,
   output logic [CNT_W-1:0]    CNT_B
);

   typedef enum logic [1:0] {IDLE, DECIDE, SEND, ACK} state_t;

   state_t              state, state_nxt;
   logic [SYNC_STAGES-1:0] send_sync, acka_sync, ackb_sync;
   logic                s_send, s_acka, s_ackb, s_ack_sel, s_ack_other;
   logic                cur, cur_nxt, br_nxt, forced, forced_nxt;
   logic [WEIGHT_W-1:0] rem, rem_nxt, w_cur, w_oth;
   logic                sendout_a_nxt, sendout_b_nxt, ackout_nxt, done;

   assign s_send      = send_sync[SYNC_STAGES-1];
   assign s_acka      = acka_sync[SYNC_STAGES-1];
   assign s_ackb      = ackb_sync[SYNC_STAGES-1];
   assign s_ack_sel   = BR ? s_ackb : s_acka;
   assign s_ack_other = BR ? s_acka : s_ackb;
   assign w_cur       = cur ? WEIGHT_B : WEIGHT_A;
   assign w_oth       = cur ? WEIGHT_A : WEIGHT_B;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         send_sync <= '0;
         acka_sync <= '0;
         ackb_sync <= '0;
      end else begin
         send_sync <= {send_sync[SYNC_STAGES-2:0], SENDIN};
         acka_sync <= {acka_sync[SYNC_STAGES-2:0], ACKINA};
         ackb_sync <= {ackb_sync[SYNC_STAGES-2:0], ACKINB};
      end
   end

   // SENDOUT is raised one cycle after entering SEND so BR is already stable for a full cycle.
   always_comb begin
      state_nxt     = state;
      cur_nxt       = cur;
      rem_nxt       = rem;
      br_nxt        = BR;
      forced_nxt    = forced;
      sendout_a_nxt = 1'b0;
      sendout_b_nxt = 1'b0;
      ackout_nxt    = 1'b0;
      done          = 1'b0;
      case (state)
         IDLE: begin
            if (s_send && EN) state_nxt = DECIDE;
         end
         DECIDE: begin
            state_nxt  = SEND;
            forced_nxt = FORCE_VALID;
            if (FORCE_VALID) begin
               br_nxt = FORCE_BR;
            end else if (WEIGHT_A == '0 && WEIGHT_B == '0) begin
               cur_nxt = ~cur;
               br_nxt  = ~cur;
            end else begin
               if (rem == '0 || w_cur == '0) begin
                  if (w_oth != '0) begin
                     cur_nxt = ~cur;
                     rem_nxt = w_oth;
                  end else begin
                     rem_nxt = w_cur;
                  end
               end
               br_nxt = cur_nxt;
            end
         end
         SEND: begin
            if (s_ack_sel) begin
               state_nxt  = ACK;
               ackout_nxt = 1'b1;
            end else begin
               sendout_a_nxt = ~BR;
               sendout_b_nxt = BR;
            end
         end
         ACK: begin
            if (!s_send && !s_ack_sel) begin
               state_nxt = IDLE;
               done      = 1'b1;
               if (!forced && rem != '0) rem_nxt = rem - 1'b1;
            end else begin
               ackout_nxt = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state    <= IDLE;
         cur      <= 1'b1;
         rem      <= '0;
         forced   <= 1'b0;
         BR       <= 1'b0;
         SENDOUTA <= 1'b0;
         SENDOUTB <= 1'b0;
         ACKOUT   <= 1'b0;
         BUSY     <= 1'b0;
         ERR      <= 1'b0;
         CNT_A    <= '0;
         CNT_B    <= '0;
      end else begin
         state    <= state_nxt;
         cur      <= cur_nxt;
         rem      <= rem_nxt;
         forced   <= forced_nxt;
         BR       <= br_nxt;
         SENDOUTA <= sendout_a_nxt;
         SENDOUTB <= sendout_b_nxt;
         ACKOUT   <= ackout_nxt;
         BUSY     <= (state_nxt != IDLE);
         ERR      <= ERR | s_ack_other;
         if (done && !BR) CNT_A <= CNT_A + 1'b1;
         if (done && BR)  CNT_B <= CNT_B + 1'b1;
      end
   end

endmodule
